img_readout_framer: RTL and testbench



---
 rtl/img_readout_framer.sv | 192 +++++++++++++++++++
 tb/tb_img_readout_framer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_readout_framer.sv
// Frames one captured image as header, width*height pixel words and an optional checksum trailer.
// Optional trailer: define IMG_READOUT_FRAMER_CHECKSUM_EN to append a 32-bit pixel sum as two words.
module img_readout_framer #(
   parameter int          ImageWidthMax  = 256,
   parameter int          ImageHeightMax = 256,
   parameter logic [15:0] HeaderMagic    = 16'h4D44,
   localparam int         WW             = $clog2(ImageWidthMax + 1),
   localparam int         HW             = $clog2(ImageHeightMax + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_start,
   input  logic [WW-1:0] cmd_width,
   input  logic [HW-1:0] cmd_height,
   input  logic [17:0]   cmd_highlightCount,
   input  logic [17:0]   cmd_shadowCount,
   input  logic          readout_ready,
   output logic          readout_trigger,
   input  logic [15:0]   readout_data,
   output logic          out_ready,
   input  logic          out_trigger,
   output logic [15:0]   out_data,
   output logic          status_busy,
   output logic          status_done
);

`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, PIXELS = 2'd2, TRAILER = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, PIXELS = 2'd2} state_t;
`endif

   localparam logic [WW-1:0] W_ONE = {{(WW-1){1'b0}}, 1'b1};
   localparam logic [HW-1:0] H_ONE = {{(HW-1){1'b0}}, 1'b1};

   state_t        state_r;
   logic [2:0]    hdr_idx_r;
   logic [WW-1:0] width_r;
   logic [HW-1:0] height_r;
   logic [WW-1:0] x_r;
   logic [HW-1:0] y_r;
   logic [17:0]   hl_r;
   logic [17:0]   sh_r;
   logic          out_ready_r;
   logic [15:0]   out_data_r;
   logic          busy_r;
   logic          done_r;
   logic          last_r;
   logic [15:0]   hdr_word_s;
   logic          can_load_s;
   logic          out_xfer_s;
   logic          rd_xfer_s;
`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
   logic [31:0]   sum_r;
   logic          trl_idx_r;
`endif

   assign can_load_s      = !out_ready_r || out_trigger;
   assign out_xfer_s      = out_ready_r && out_trigger;
   assign readout_trigger = (state_r == PIXELS) && can_load_s;
   assign rd_xfer_s       = readout_trigger && readout_ready;

   assign out_ready   = out_ready_r;
   assign out_data    = out_data_r;
   assign status_busy = busy_r;
   assign status_done = done_r;

   // Header word selection; word 0 (magic) is loaded directly on cmd_start
   always_comb begin
      hdr_word_s = HeaderMagic;
      case (hdr_idx_r)
         3'd1:    hdr_word_s = {{(16-WW){1'b0}}, width_r};
         3'd2:    hdr_word_s = {{(16-HW){1'b0}}, height_r};
         3'd3:    hdr_word_s = hl_r[15:0];
         3'd4:    hdr_word_s = {14'b0, hl_r[17:16]};
         3'd5:    hdr_word_s = sh_r[15:0];
         3'd6:    hdr_word_s = {14'b0, sh_r[17:16]};
         default: hdr_word_s = HeaderMagic;
      endcase
   end

   // Framing FSM and output register. After the final word loads the FSM parks in IDLE
   // with last_r set, so it waits for that word to be accepted before completing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         hdr_idx_r   <= 3'd0;
         width_r     <= '0;
         height_r    <= '0;
         x_r         <= '0;
         y_r         <= '0;
         hl_r        <= 18'd0;
         sh_r        <= 18'd0;
         out_ready_r <= 1'b0;
         out_data_r  <= 16'h0000;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         last_r      <= 1'b0;
`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
         sum_r       <= 32'd0;
         trl_idx_r   <= 1'b0;
`endif
      end else begin
         if (out_xfer_s) out_ready_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (last_r) begin
                  if (out_xfer_s) begin
                     last_r <= 1'b0;
                     busy_r <= 1'b0;
                     done_r <= ~done_r;
                  end
               end else if (cmd_start && !busy_r) begin
                  width_r     <= cmd_width;
                  height_r    <= cmd_height;
                  hl_r        <= cmd_highlightCount;
                  sh_r        <= cmd_shadowCount;
                  x_r         <= W_ONE;
                  y_r         <= H_ONE;
                  busy_r      <= 1'b1;
                  out_data_r  <= HeaderMagic;
                  out_ready_r <= 1'b1;
                  hdr_idx_r   <= 3'd1;
                  state_r     <= HEADER;
`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
                  sum_r       <= 32'd0;
`endif
               end
            end
            HEADER: begin
               if (can_load_s) begin
                  out_data_r  <= hdr_word_s;
                  out_ready_r <= 1'b1;
                  hdr_idx_r   <= hdr_idx_r + 3'd1;
                  if (hdr_idx_r == 3'd6) begin
                     if (width_r == '0 || height_r == '0) begin
`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
                        trl_idx_r <= 1'b0;
                        state_r   <= TRAILER;
`else
                        last_r    <= 1'b1;
                        state_r   <= IDLE;
`endif
                     end else begin
                        state_r <= PIXELS;
                     end
                  end
               end
            end
            PIXELS: begin
               if (rd_xfer_s) begin
                  out_data_r  <= readout_data;
                  out_ready_r <= 1'b1;
`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
                  sum_r       <= sum_r + {16'h0000, readout_data};
`endif
                  if (x_r == width_r) begin
                     x_r <= W_ONE;
                     y_r <= y_r + H_ONE;
                     if (y_r == height_r) begin
`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
                        trl_idx_r <= 1'b0;
                        state_r   <= TRAILER;
`else
                        last_r    <= 1'b1;
                        state_r   <= IDLE;
`endif
                     end
                  end else begin
                     x_r <= x_r + W_ONE;
                  end
               end
            end
`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
            TRAILER: begin
               if (can_load_s) begin
                  out_data_r  <= trl_idx_r ? sum_r[31:16] : sum_r[15:0];
                  out_ready_r <= 1'b1;
                  trl_idx_r   <= 1'b1;
                  if (trl_idx_r) begin
                     last_r  <= 1'b1;
                     state_r <= IDLE;
                  end
               end
            end
`endif
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_img_readout_framer.sv
// Self-checking bench for img_readout_framer: table of frames plus hand-written corner sequences,
// with a scoreboard queue of expected output words.
module tb_img_readout_framer;

`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
   localparam int TRL = 2;
`else
   localparam int TRL = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_start;
   logic [8:0]  cmd_width;
   logic [8:0]  cmd_height;
   logic [17:0] cmd_highlightCount;
   logic [17:0] cmd_shadowCount;
   logic        readout_ready;
   logic        readout_trigger;
   logic [15:0] readout_data;
   logic        out_ready;
   logic        out_trigger;
   logic [15:0] out_data;
   logic        status_busy;
   logic        status_done;

   always #5 clk = ~clk;

   img_readout_framer dut (
      .clk                (clk),
      .rst                (rst),
      .cmd_start          (cmd_start),
      .cmd_width          (cmd_width),
      .cmd_height         (cmd_height),
      .cmd_highlightCount (cmd_highlightCount),
      .cmd_shadowCount    (cmd_shadowCount),
      .readout_ready      (readout_ready),
      .readout_trigger    (readout_trigger),
      .readout_data       (readout_data),
      .out_ready          (out_ready),
      .out_trigger        (out_trigger),
      .out_data           (out_data),
      .status_busy        (status_busy),
      .status_done        (status_done)
   );

   typedef struct {
      int          w;
      int          h;
      logic [17:0] hl;
      logic [17:0] sh;
      int          kind;
      int          sink;
      int          gap;
      int          len;
      logic [31:0] sum;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];
   int          pix_idx, pops, accepted, cyc;
   int          kind_g, sink_g, gap_g;
   bit          rd_done, pend_valid;
   logic [15:0] pend_word;
   vec_t        vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [15:0] pix(input int kind, input int i);
      case (kind)
         0:       return 16'(i + 1);
         1:       return 16'hFFFF;
         default: return 16'(i * 37 + 5);
      endcase
   endfunction

   task automatic push_frame(input vec_t v);
      exp_q.push_back(16'h4D44);
      exp_q.push_back(16'(v.w));
      exp_q.push_back(16'(v.h));
      exp_q.push_back(v.hl[15:0]);
      exp_q.push_back({14'b0, v.hl[17:16]});
      exp_q.push_back(v.sh[15:0]);
      exp_q.push_back({14'b0, v.sh[17:16]});
      for (int i = 0; i < v.w * v.h; i++) exp_q.push_back(pix(v.kind, i));
`ifdef IMG_READOUT_FRAMER_CHECKSUM_EN
      exp_q.push_back(v.sum[15:0]);
      exp_q.push_back(v.sum[31:16]);
`endif
   endtask

   // One clock cycle: drive at negedge, sample/check after settling, then advance to next negedge.
   task automatic step();
      out_trigger = (sink_g == 0) ? 1'b1 : (sink_g == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      if (!readout_ready || rd_done)
         readout_ready = (gap_g == 0) ? 1'b1 : ($urandom_range(0, gap_g - 1) != 0);
      rd_done = 1'b0;
      readout_data = pix(kind_g, pix_idx);
      #1;
      if (pend_valid) begin
         check("pix_latency", {15'b0, out_ready, out_data}, {15'b0, 1'b1, pend_word});
         pend_valid = 1'b0;
      end
      if (out_ready && !out_trigger) check("rtrig_stall", {31'b0, readout_trigger}, 32'd0);
      if (out_ready && out_trigger) begin
         accepted++;
         check("busy_during", {31'b0, status_busy}, 32'd1);
         if (exp_q.size() == 0) check("extra_word", {16'b0, out_data}, 32'hDEAD_0000);
         else check("out_word", {16'b0, out_data}, {16'b0, exp_q.pop_front()});
      end
      if (readout_trigger && readout_ready) begin
         pend_word  = readout_data;
         pend_valid = 1'b1;
         rd_done    = 1'b1;
         pops++;
         pix_idx++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic start_frame(input vec_t v);
      kind_g = v.kind; sink_g = v.sink; gap_g = v.gap;
      pix_idx = 0; pops = 0; accepted = 0; pend_valid = 1'b0;
      push_frame(v);
      cmd_start = 1'b1;
      cmd_width = 9'(v.w);
      cmd_height = 9'(v.h);
      cmd_highlightCount = v.hl;
      cmd_shadowCount = v.sh;
      step();
      cmd_start = 1'b0;
      check("start_ready", {15'b0, out_ready, out_data}, {15'b0, 1'b1, 16'h4D44});
   endtask

   task automatic run_frame(input vec_t v, input bit midstart);
      logic start_done;
      bit   ms_done;
      int   budget;
      start_done = status_done;
      ms_done = 1'b0;
      budget = (v.w * v.h + 20) * 8 + 100;
      start_frame(v);
      for (int c = 0; c < budget && status_done == start_done; c++) begin
         if (midstart && !ms_done && pops == 4) begin
            cmd_start = 1'b1; cmd_width = 9'd1; cmd_height = 9'd1;
            cmd_highlightCount = 18'h0; cmd_shadowCount = 18'h0;
            ms_done = 1'b1;
         end
         step();
         cmd_start = 1'b0;
      end
      check("done_toggle", {31'b0, status_done}, {31'b0, ~start_done});
      check("busy_end", {31'b0, status_busy}, 32'd0);
      check("frame_len", accepted, v.len + TRL);
      check("queue_empty", exp_q.size(), 32'd0);
      exp_q.delete();
      for (int c = 0; c < 5; c++) step();
      check("pops", pops, v.w * v.h);
      check("done_stable", {31'b0, status_done}, {31'b0, ~start_done});
   endtask

   initial begin
      //          w    h    hl         sh         kind sink gap len       sum
      vecs[0] = '{2,   2,   18'h20001, 18'h00005, 0,   0,   0,  11,       32'h0000_000A};
      vecs[1] = '{2,   2,   18'h20001, 18'h00005, 0,   1,   0,  11,       32'h0000_000A};
      vecs[2] = '{0,   3,   18'h3FFFF, 18'h12345, 0,   0,   0,  7,        32'h0000_0000};
      vecs[3] = '{3,   1,   18'h00000, 18'h00000, 0,   2,   3,  10,       32'h0000_0006};
      vecs[4] = '{5,   0,   18'h00001, 18'h00002, 0,   0,   0,  7,        32'h0000_0000};
      vecs[5] = '{3,   3,   18'h10010, 18'h2ABCD, 2,   2,   2,  16,       32'h0000_0561};
      vecs[6] = '{256, 256, 18'h00001, 18'h00002, 1,   0,   32, 7 + 65536, 32'hFFFF_0000};

      rst = 1'b1; cmd_start = 1'b0; cmd_width = 9'd0; cmd_height = 9'd0;
      cmd_highlightCount = 18'd0; cmd_shadowCount = 18'd0;
      readout_ready = 1'b0; readout_data = 16'h0000; out_trigger = 1'b0;
      cyc = 0; rd_done = 1'b0; pend_valid = 1'b0; kind_g = 0; sink_g = 0; gap_g = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_ready", {31'b0, out_ready}, 32'd0);
      check("rst_out_data", {16'b0, out_data}, 32'd0);
      check("rst_rtrig", {31'b0, readout_trigger}, 32'd0);
      check("rst_busy", {31'b0, status_busy}, 32'd0);
      check("rst_done", {31'b0, status_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_frame(vecs[i], 1'b0);

      // cmd_start mid-pixels must not disturb the frame in progress
      run_frame(vecs[5], 1'b1);

      // reset mid-pixels abandons the frame; a fresh start then frames cleanly
      begin
         vec_t v;
         v = '{4, 4, 18'h00003, 18'h00004, 0, 0, 0, 23, 32'h0000_0088};
         start_frame(v);
         for (int c = 0; c < 100 && pops < 5; c++) step();
         check("mid_pops", pops, 32'd5);
         rst = 1'b1;
         #1;
         check("mrst_out_ready", {31'b0, out_ready}, 32'd0);
         check("mrst_out_data", {16'b0, out_data}, 32'd0);
         check("mrst_rtrig", {31'b0, readout_trigger}, 32'd0);
         check("mrst_busy", {31'b0, status_busy}, 32'd0);
         check("mrst_done", {31'b0, status_done}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         check("mrst_hold", {29'b0, out_ready, status_busy, status_done}, 32'd0);
         rst = 1'b0;
         exp_q.delete();
         pend_valid = 1'b0;
         @(negedge clk);
         run_frame(vecs[0], 1'b0);
      end

      run_frame(vecs[6], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
